// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with bounded retries,
// qualifies lock stability, then releases sys_rst. Optional macro: PLL_LOCK_LOSS_CNT_EN.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (relock_req) begin
      state_d = S_PLL_RST;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_LAST) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_PLL_RST;
              retry_d = retry_q + 2'd1;
            end
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          if (!locked_s) state_d = S_PLL_RST;
        end
        S_FAULT: ;
        default: state_d = S_PLL_RST;
      endcase
    end
    // relock_req in PLL_RST keeps the state but must still restart the pulse count
    if (relock_req || (state_d != state_q)) cnt_d = '0;
  end

  // Outputs are decoded from the next state and registered, so each value
  // appears in the first cycle of its state.
  always_comb begin
    pll_rst_d = 1'b0;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (state_d)
      S_PLL_RST: pll_rst_d = 1'b1;
      S_RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      S_FAULT: begin
        pll_rst_d = 1'b1;
        fault_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  // A relock request in the same cycle wins, so it is not a lock-loss event.
  assign loss_evt = (state_q == S_RUN) && !locked_s && !relock_req;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: phase/age reference model checked every
// cycle, plus literal expectations for the nominal, timeout, glitch, loss, relock and reset cases.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int PH_RST   = 11;
  localparam int PH_WAIT  = 22;
  localparam int PH_STAB  = 33;
  localparam int PH_RUN   = 44;
  localparam int PH_FAULT = 55;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: current phase, cycles spent in it, retries, losses.
  int m_phase = PH_RST;
  int m_age   = 0;
  int m_retry = 0;
  int m_loss  = 0;
  int cyc     = 0;
  bit hist[$] = '{1'b0, 1'b0};
  bit ls;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_step(input bit lk);
    int  nxt;
    bit  restart;
    nxt = m_phase;
    restart = 1'b0;
    if (relock_req) begin
      nxt = PH_RST;
      restart = 1'b1;
      m_retry = 0;
    end else begin
      case (m_phase)
        PH_RST:  if (m_age + 1 == RST_CYCLES) nxt = PH_WAIT;
        PH_WAIT: begin
          if (lk) nxt = PH_STAB;
          else if (m_age + 1 == LOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRY - 1) nxt = PH_FAULT;
            else begin
              m_retry++;
              nxt = PH_RST;
            end
          end
        end
        PH_STAB: begin
          if (!lk) nxt = PH_WAIT;
          else if (m_age + 1 == STABLE_CYCLES) begin
            nxt = PH_RUN;
            m_retry = 0;
          end
        end
        PH_RUN: begin
          if (!lk) begin
            nxt = PH_RST;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
    if (restart || nxt != m_phase) m_age = 0;
    else m_age++;
    m_phase = nxt;
  endtask

  // locked seen by the sequencer at edge k is the raw sample taken at edge k-2.
  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = PH_RST;
      m_age   = 0;
      m_retry = 0;
      m_loss  = 0;
      cyc     = 0;
      hist    = '{1'b0, 1'b0};
    end else begin
      ls = hist[1];
      model_step(ls);
      hist.push_front(locked);
      void'(hist.pop_back());
      cyc++;
    end
  end

  always @(negedge refclk) begin
    chk("pll_rst", int'(pll_rst), int'(m_phase == PH_RST || m_phase == PH_FAULT));
    chk("sys_rst", int'(sys_rst), int'(m_phase != PH_RUN));
    chk("ready", int'(ready), int'(m_phase == PH_RUN));
    chk("fault", int'(fault), int'(m_phase == PH_FAULT));
    chk("retry_cnt", int'(retry_cnt), m_retry);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
`endif
  end

  task automatic goto(input int n);
    int g;
    g = 0;
    do begin
      @(negedge refclk);
      g++;
    end while (cyc != n && g < 500);
    if (cyc != n) begin
      total_cnt++;
      $display("FAIL goto: reached cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic release_rst();
    @(posedge refclk);
    #1 rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge refclk);
    #2 rst = 1'b1;
    repeat (2) @(negedge refclk);
    release_rst();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge refclk);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_rst", int'(sys_rst), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_retry", int'(retry_cnt), 0);

    // Never locks: two timeouts, then sticky fault; relock clears it.
    release_rst();
    goto(0);   chk("nl_c0_pll_rst", int'(pll_rst), 1);
    goto(3);   chk("nl_c3_pll_rst", int'(pll_rst), 1);
    goto(4);   chk("nl_c4_pll_rst", int'(pll_rst), 0);
    goto(23);  chk("nl_c23_pll_rst", int'(pll_rst), 0);
               chk("nl_c23_retry", int'(retry_cnt), 0);
    goto(24);  chk("nl_c24_pll_rst", int'(pll_rst), 1);
               chk("nl_c24_retry", int'(retry_cnt), 1);
    goto(27);  chk("nl_c27_pll_rst", int'(pll_rst), 1);
    goto(28);  chk("nl_c28_pll_rst", int'(pll_rst), 0);
    goto(47);  chk("nl_c47_fault", int'(fault), 0);
    goto(48);  chk("nl_c48_fault", int'(fault), 1);
               chk("nl_c48_pll_rst", int'(pll_rst), 1);
               chk("nl_c48_retry", int'(retry_cnt), 1);
    goto(100); chk("nl_c100_fault", int'(fault), 1);
               relock_req = 1'b1;
    goto(101); relock_req = 1'b0;
               chk("rl_fault", int'(fault), 0);
               chk("rl_retry", int'(retry_cnt), 0);
               chk("rl_pll_rst", int'(pll_rst), 1);

    // Nominal lock, two lock losses in RUN, relock coinciding with a loss.
    do_reset();
    goto(3);   chk("nom_c3_pll_rst", int'(pll_rst), 1);
    goto(4);   chk("nom_c4_pll_rst", int'(pll_rst), 0);
    goto(10);  locked = 1'b1;
    goto(20);  chk("nom_c20_ready", int'(ready), 0);
    goto(21);  chk("nom_c21_ready", int'(ready), 1);
               chk("nom_c21_sys_rst", int'(sys_rst), 0);
    goto(30);  locked = 1'b0;
    goto(32);  chk("ll1_c32_ready", int'(ready), 1);
    goto(33);  chk("ll1_c33_ready", int'(ready), 0);
               chk("ll1_c33_sys_rst", int'(sys_rst), 1);
               chk("ll1_c33_pll_rst", int'(pll_rst), 1);
`ifdef PLL_LOCK_LOSS_CNT_EN
               chk("ll1_loss_cnt", int'(lock_loss_cnt), 1);
`endif
    goto(36);  chk("ll1_c36_pll_rst", int'(pll_rst), 1);
    goto(37);  chk("ll1_c37_pll_rst", int'(pll_rst), 0);
               locked = 1'b1;
    goto(47);  chk("ll1_c47_ready", int'(ready), 0);
    goto(48);  chk("ll1_c48_ready", int'(ready), 1);
    goto(50);  locked = 1'b0;
    goto(53);  chk("ll2_c53_ready", int'(ready), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
               chk("ll2_loss_cnt", int'(lock_loss_cnt), 2);
`endif
               locked = 1'b1;
    goto(66);  chk("ll2_c66_ready", int'(ready), 1);
    goto(70);  locked = 1'b0;
    goto(72);  relock_req = 1'b1;
    goto(73);  relock_req = 1'b0;
               chk("rlx_ready", int'(ready), 0);
               chk("rlx_pll_rst", int'(pll_rst), 1);
               chk("rlx_retry", int'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
               chk("rlx_loss_cnt", int'(lock_loss_cnt), 2);
`endif

    // Glitch at STABLE cnt=5 forces a full new stability window.
    do_reset();
    goto(10);  locked = 1'b1;
    goto(18);  locked = 1'b0;
    goto(20);  chk("gl_c20_ready", int'(ready), 0);
    goto(21);  locked = 1'b1;
               chk("gl_c21_pll_rst", int'(pll_rst), 0);
               chk("gl_c21_ready", int'(ready), 0);
    goto(31);  chk("gl_c31_ready", int'(ready), 0);
               chk("gl_c31_sys_rst", int'(sys_rst), 1);
    goto(32);  chk("gl_c32_ready", int'(ready), 1);

    // Asynchronous reset at STABLE cnt=3, then a full restart.
    do_reset();
    goto(10);  locked = 1'b1;
    goto(16);
    #2 rst = 1'b1;
    #1;
    chk("ar_pll_rst", int'(pll_rst), 1);
    chk("ar_sys_rst", int'(sys_rst), 1);
    chk("ar_ready", int'(ready), 0);
    chk("ar_fault", int'(fault), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("ar_loss_cnt", int'(lock_loss_cnt), 0);
`endif
    repeat (2) @(negedge refclk);
    release_rst();
    goto(3);   chk("ar_c3_pll_rst", int'(pll_rst), 1);
    goto(4);   chk("ar_c4_pll_rst", int'(pll_rst), 0);
    goto(12);  chk("ar_c12_ready", int'(ready), 0);
    goto(13);  chk("ar_c13_ready", int'(ready), 1);
    goto(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
